// File: rtl/multi_signal_generator.sv
`default_nettype none
//==============================================================================
// Module   : multi_signal_generator
// Purpose  : NUM_CHANNELS sine/square/triangle/saw generators with updates
//            applied on phase wrap, plus an averaged mix of all channels.
// Revision : 1.0
//==============================================================================
module multi_signal_generator #(
    parameter int NUM_CHANNELS = 4,
    parameter int FREQ_WIDTH   = 14,
    parameter int SAMPLE_WIDTH = 8,
    parameter int SAMPLE_RATE  = 32000,
    parameter int TABLE_DEPTH  = 128,
    localparam int c_CHW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                                 CLK_32KHz,
    input  logic                                 reset,
    input  logic                                 cfg_valid,
    output logic                                 cfg_ready,
    input  logic [c_CHW-1:0]                     cfg_ch,
    input  logic [FREQ_WIDTH-1:0]                cfg_freq,
    input  logic [SAMPLE_WIDTH-1:0]              cfg_amp,
    input  logic [1:0]                           cfg_mode,
    output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] samples,
    output logic [SAMPLE_WIDTH-1:0]              mix,
    output logic [NUM_CHANNELS-1:0]              index_zero
);
    localparam int     c_W      = SAMPLE_WIDTH;
    localparam int     c_PW     = $clog2(SAMPLE_RATE) + 1;
    localparam int     c_SW     = c_PW + 1;
    localparam int     c_IW     = $clog2(TABLE_DEPTH);
    localparam int     c_M      = (1 << c_W) - 1;
    localparam int     c_HM     = c_M / 2;
    localparam int     c_HALF_D = TABLE_DEPTH / 2;
    localparam int     c_STEP   = SAMPLE_RATE / TABLE_DEPTH;
    localparam int     c_F_MAX  = SAMPLE_RATE / 2;
    localparam int     c_SUMW   = c_W + $clog2(NUM_CHANNELS);
    localparam int     c_PEXT   = 1 << c_CHW;
    localparam longint c_PI_Q30 = 64'sd3373259426;

    // Integer Q30 cosine (Taylor series on a quarter wave) so the table
    // is built without real arithmetic; quarter points are forced exact.
    function automatic logic [SAMPLE_WIDTH-1:0] sine_point(input int idx);
        longint one, x, x2, term, c, num;
        int     j;
        bit     neg;
        one = 64'sd1 <<< 30;
        j   = (idx > TABLE_DEPTH / 2) ? TABLE_DEPTH - idx : idx;
        neg = 1'b0;
        if (j > TABLE_DEPTH / 4) begin
            j   = TABLE_DEPTH / 2 - j;
            neg = 1'b1;
        end
        if (4 * j == TABLE_DEPTH) begin
            c = 0;
        end else begin
            x    = (c_PI_Q30 * 2 * longint'(j)) / longint'(TABLE_DEPTH);
            x2   = (x * x) >>> 30;
            term = one;
            c    = one;
            for (int k = 1; k <= 10; k++) begin
                term = -((term * x2) >>> 30) / longint'((2 * k - 1) * (2 * k));
                c    = c + term;
            end
        end
        if (neg) c = -c;
        num = (one - c) * longint'(c_M) + one;
        return SAMPLE_WIDTH'(num >>> 31);
    endfunction

    logic [c_W-1:0] w_sine_tab [TABLE_DEPTH];
    for (genvar gi = 0; gi < TABLE_DEPTH; gi++) begin : g_sine
        localparam logic [c_W-1:0] c_VAL = sine_point(gi);
        assign w_sine_tab[gi] = c_VAL;
    end

    logic [NUM_CHANNELS*c_W-1:0] w_next_samples;
    logic [NUM_CHANNELS-1:0]     w_next_iz;
    logic [NUM_CHANNELS-1:0]     w_pend;
    logic [c_PEXT-1:0]           w_pend_ext;
    logic [c_PW-1:0]             w_freq_in;
    logic [c_SUMW-1:0]           w_sum_all;
    logic [c_W-1:0]              w_mix;
    logic [NUM_CHANNELS*c_W-1:0] r_samples;
    logic [c_W-1:0]              r_mix;
    logic [NUM_CHANNELS-1:0]     r_iz;

    assign w_pend_ext = c_PEXT'(w_pend);
    assign cfg_ready  = ~w_pend_ext[cfg_ch];
    assign w_freq_in  = (int'(cfg_freq) > c_F_MAX) ? c_PW'(c_F_MAX) : c_PW'(cfg_freq);

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        logic [c_PW-1:0] r_phase, r_freq, r_sh_freq;
        logic [c_W-1:0]  r_amp, r_sh_amp;
        logic [1:0]      r_mode, r_sh_mode;
        logic            r_pend;
        logic [c_SW-1:0] w_sum;
        logic            w_wrap, w_accept, w_apply;
        logic [c_IW-1:0] w_idx;
        logic [c_W-1:0]  w_wave, w_out;

        assign w_sum    = {1'b0, r_phase} + {1'b0, r_freq};
        assign w_wrap   = (w_sum >= c_SW'(SAMPLE_RATE));
        assign w_accept = cfg_valid && cfg_ready && (cfg_ch == c_CHW'(g));
        // A stopped channel has no wrap to wait for, so it takes the update at once.
        assign w_apply  = r_pend && (w_wrap || (r_freq == '0));

        always_ff @(posedge CLK_32KHz or posedge reset) begin
            if (reset) begin
                r_phase   <= '0;
                r_freq    <= '0;
                r_amp     <= '0;
                r_mode    <= '0;
                r_sh_freq <= '0;
                r_sh_amp  <= '0;
                r_sh_mode <= '0;
                r_pend    <= 1'b0;
            end else begin
                r_phase <= w_wrap ? c_PW'(w_sum - c_SW'(SAMPLE_RATE)) : c_PW'(w_sum);
                if (w_apply) begin
                    r_freq <= r_sh_freq;
                    r_amp  <= r_sh_amp;
                    r_mode <= r_sh_mode;
                    r_pend <= 1'b0;
                end else if (w_accept) begin
                    r_sh_freq <= w_freq_in;
                    r_sh_amp  <= cfg_amp;
                    r_sh_mode <= cfg_mode;
                    r_pend    <= 1'b1;
                end
            end
        end

        always_comb begin
            w_idx  = c_IW'(r_phase / c_PW'(c_STEP));
            w_wave = '0;
            case (r_mode)
                2'd0: w_wave = w_sine_tab[w_idx];
                2'd1: w_wave = (int'(w_idx) < c_HALF_D) ? c_W'(c_M) : '0;
                2'd2: w_wave = (int'(w_idx) < c_HALF_D)
                             ? c_W'((int'(w_idx) * c_M) / c_HALF_D)
                             : c_W'(((TABLE_DEPTH - int'(w_idx)) * c_M) / c_HALF_D);
                default: w_wave = c_W'((int'(w_idx) * c_M) / (TABLE_DEPTH - 1));
            endcase
            w_out = c_W'((longint'(w_wave) * longint'(r_amp) + longint'(c_HM)) / longint'(c_M));
        end

        assign w_next_samples[g*c_W +: c_W] = w_out;
        assign w_next_iz[g]                 = (w_idx == '0);
        assign w_pend[g]                    = r_pend;
    end

    always_comb begin
        w_sum_all = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_sum_all = w_sum_all + c_SUMW'(w_next_samples[i*c_W +: c_W]);
        end
        w_mix = c_W'(w_sum_all / c_SUMW'(NUM_CHANNELS));
    end

    always_ff @(posedge CLK_32KHz or posedge reset) begin
        if (reset) begin
            r_samples <= '0;
            r_mix     <= '0;
            r_iz      <= '1;
        end else begin
            r_samples <= w_next_samples;
            r_mix     <= w_mix;
            r_iz      <= w_next_iz;
        end
    end

    assign samples    = r_samples;
    assign mix        = r_mix;
    assign index_zero = r_iz;

endmodule
`default_nettype wire

// File: tb/tb_multi_signal_generator.sv
`default_nettype none
//==============================================================================
// Module   : tb_multi_signal_generator
// Purpose  : Directed self-checking bench for multi_signal_generator.
// Revision : 1.0
//==============================================================================
module tb_multi_signal_generator;
    logic        clk;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [14:0] cfg_freq;
    logic [7:0]  cfg_amp;
    logic [1:0]  cfg_mode;
    logic [31:0] samples;
    logic [7:0]  mix;
    logic [3:0]  index_zero;

    int n_vec = 0;
    int n_err = 0;

    // Frequency port widened by one bit so the 20000 Hz clamp case is representable.
    multi_signal_generator #(
        .NUM_CHANNELS(4),
        .FREQ_WIDTH  (15),
        .SAMPLE_WIDTH(8),
        .SAMPLE_RATE (32000),
        .TABLE_DEPTH (128)
    ) dut (
        .CLK_32KHz (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_freq  (cfg_freq),
        .cfg_amp   (cfg_amp),
        .cfg_mode  (cfg_mode),
        .samples   (samples),
        .mix       (mix),
        .index_zero(index_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] smp(input int ch);
        return samples[ch*8 +: 8];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        cfg_valid = 1'b0;
        reset     = 1'b1;
        #2;
        reset     = 1'b0;
    endtask

    task automatic cfg_write(input int ch, input int fr, input int amp, input int mode);
        cfg_ch    = 2'(ch);
        cfg_freq  = 15'(fr);
        cfg_amp   = 8'(amp);
        cfg_mode  = 2'(mode);
        cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        for (int r = 0; r < 2; r++) begin
            n_vec++; if (samples !== 32'h0) begin n_err++; $display("FAIL reset_samples got=%h exp=0", samples); end
            n_vec++; if (mix !== 8'h0) begin n_err++; $display("FAIL reset_mix got=%0d exp=0", mix); end
            n_vec++; if (index_zero !== 4'hF) begin n_err++; $display("FAIL reset_index_zero got=%b exp=1111", index_zero); end
            n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
            tick(1);
        end
        reset = 1'b0;
    endtask

    task automatic test_sine;
        int exp_v;
        do_reset();
        cfg_write(0, 1000, 255, 0);
        n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL sine_ready_pending got=%b exp=0", cfg_ready); end
        tick(1);
        n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL sine_ready_applied got=%b exp=1", cfg_ready); end
        for (int t = 0; t < 64; t++) begin
            tick(1);
            n_vec++;
            if (index_zero[0] !== (t % 32 == 0)) begin
                n_err++; $display("FAIL sine_index_zero t=%0d got=%b exp=%b", t, index_zero[0], (t % 32 == 0));
            end
            case (t)
                0, 32:   exp_v = 0;
                1:       exp_v = 2;
                2:       exp_v = 10;
                4:       exp_v = 37;
                8, 24:   exp_v = 128;
                16:      exp_v = 255;
                default: exp_v = -1;
            endcase
            if (exp_v >= 0) begin
                n_vec++;
                if (smp(0) !== 8'(exp_v)) begin n_err++; $display("FAIL sine_sample t=%0d got=%0d exp=%0d", t, smp(0), exp_v); end
            end
            if (t == 16) begin
                n_vec++; if (mix !== 8'd63) begin n_err++; $display("FAIL sine_mix got=%0d exp=63", mix); end
            end
        end
    endtask

    task automatic test_square;
        do_reset();
        cfg_write(1, 500, 255, 1);
        tick(1);
        for (int t = 0; t < 64; t++) begin
            tick(1);
            n_vec++;
            if (smp(1) !== ((t < 32) ? 8'd255 : 8'd0)) begin
                n_err++; $display("FAIL square_sample t=%0d got=%0d exp=%0d", t, smp(1), (t < 32) ? 255 : 0);
            end
        end
    endtask

    task automatic test_amplitude;
        do_reset();
        cfg_write(2, 1000, 128, 0);
        tick(1);
        for (int t = 0; t <= 16; t++) begin
            tick(1);
            if (t == 8) begin
                n_vec++; if (smp(2) !== 8'd64) begin n_err++; $display("FAIL amp_half got=%0d exp=64", smp(2)); end
            end
            if (t == 16) begin
                n_vec++; if (smp(2) !== 8'd128) begin n_err++; $display("FAIL amp_peak got=%0d exp=128", smp(2)); end
            end
        end
    endtask

    task automatic test_tri_saw;
        do_reset();
        cfg_write(0, 1000, 255, 2);
        cfg_write(1, 1000, 255, 3);
        for (int u = 0; u <= 32; u++) begin
            tick(1);
            if (u == 1)  begin n_vec++; if (smp(0) !== 8'd15)  begin n_err++; $display("FAIL tri_i4 got=%0d exp=15", smp(0)); end end
            if (u == 8)  begin n_vec++; if (smp(0) !== 8'd127) begin n_err++; $display("FAIL tri_i32 got=%0d exp=127", smp(0)); end end
            if (u == 16) begin n_vec++; if (smp(0) !== 8'd255) begin n_err++; $display("FAIL tri_i64 got=%0d exp=255", smp(0)); end end
            if (u == 24) begin n_vec++; if (smp(0) !== 8'd127) begin n_err++; $display("FAIL tri_i96 got=%0d exp=127", smp(0)); end end
            if (u == 1)  begin n_vec++; if (smp(1) !== 8'd0)   begin n_err++; $display("FAIL saw_i0 got=%0d exp=0", smp(1)); end end
            if (u == 2)  begin n_vec++; if (smp(1) !== 8'd8)   begin n_err++; $display("FAIL saw_i4 got=%0d exp=8", smp(1)); end end
            if (u == 17) begin n_vec++; if (smp(1) !== 8'd128) begin n_err++; $display("FAIL saw_i64 got=%0d exp=128", smp(1)); end end
            if (u == 32) begin n_vec++; if (smp(1) !== 8'd248) begin n_err++; $display("FAIL saw_i124 got=%0d exp=248", smp(1)); end end
        end
    endtask

    task automatic test_deferred;
        do_reset();
        cfg_write(0, 1000, 255, 0);
        tick(1);
        tick(5);
        cfg_write(0, 2000, 255, 0);
        n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL defer_ready_low got=%b exp=0", cfg_ready); end
        cfg_ch    = 2'd0;
        cfg_freq  = 15'd3000;
        cfg_amp   = 8'd255;
        cfg_mode  = 2'd1;
        cfg_valid = 1'b1;
        tick(1);
        n_vec++; if (smp(0) !== 8'd79) begin n_err++; $display("FAIL defer_old_step1 got=%0d exp=79", smp(0)); end
        tick(2);
        n_vec++; if (smp(0) !== 8'd128) begin n_err++; $display("FAIL defer_old_step3 got=%0d exp=128", smp(0)); end
        tick(2);
        cfg_valid = 1'b0;
        tick(20);
        n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL defer_ready_prewrap got=%b exp=0", cfg_ready); end
        tick(1);
        n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL defer_ready_after got=%b exp=1", cfg_ready); end
        n_vec++; if (smp(0) !== 8'd2) begin n_err++; $display("FAIL defer_prewrap_sample got=%0d exp=2", smp(0)); end
        tick(1);
        n_vec++; if (index_zero[0] !== 1'b1) begin n_err++; $display("FAIL defer_wrap_iz got=%b exp=1", index_zero[0]); end
        for (int t = 1; t <= 16; t++) begin
            tick(1);
            n_vec++;
            if (index_zero[0] !== (t == 16)) begin
                n_err++; $display("FAIL defer_new_iz t=%0d got=%b exp=%b", t, index_zero[0], (t == 16));
            end
            if (t == 1) begin n_vec++; if (smp(0) !== 8'd10)  begin n_err++; $display("FAIL defer_new_i8 got=%0d exp=10", smp(0)); end end
            if (t == 4) begin n_vec++; if (smp(0) !== 8'd128) begin n_err++; $display("FAIL defer_new_i32 got=%0d exp=128", smp(0)); end end
            if (t == 8) begin n_vec++; if (smp(0) !== 8'd255) begin n_err++; $display("FAIL defer_new_i64 got=%0d exp=255", smp(0)); end end
        end
    endtask

    task automatic test_clamp;
        do_reset();
        cfg_write(3, 20000, 255, 1);
        tick(1);
        for (int t = 0; t < 8; t++) begin
            tick(1);
            n_vec++;
            if (smp(3) !== ((t % 2 == 0) ? 8'd255 : 8'd0)) begin
                n_err++; $display("FAIL clamp_sample t=%0d got=%0d exp=%0d", t, smp(3), (t % 2 == 0) ? 255 : 0);
            end
            n_vec++;
            if (index_zero[3] !== (t % 2 == 0)) begin
                n_err++; $display("FAIL clamp_iz t=%0d got=%b exp=%b", t, index_zero[3], (t % 2 == 0));
            end
        end
    endtask

    task automatic test_mix;
        int exp_v;
        do_reset();
        for (int c = 0; c < 4; c++) cfg_write(c, 500, 255, 1);
        for (int u = 0; u <= 62; u++) begin
            tick(1);
            case (u)
                0, 30:   exp_v = 191;
                5:       exp_v = 255;
                31:      exp_v = 127;
                33, 40:  exp_v = 0;
                62:      exp_v = 63;
                default: exp_v = -1;
            endcase
            if (exp_v >= 0) begin
                n_vec++;
                if (mix !== 8'(exp_v)) begin n_err++; $display("FAIL mix_all u=%0d got=%0d exp=%0d", u, mix, exp_v); end
            end
        end
        do_reset();
        cfg_write(0, 500, 255, 1);
        cfg_write(1, 500, 255, 1);
        cfg_write(2, 500, 0, 1);
        cfg_write(3, 500, 0, 1);
        tick(5);
        n_vec++; if (mix !== 8'd127) begin n_err++; $display("FAIL mix_half got=%0d exp=127", mix); end
        n_vec++; if (smp(2) !== 8'd0) begin n_err++; $display("FAIL mix_zero_amp got=%0d exp=0", smp(2)); end
    endtask

    task automatic test_reset_midrun;
        do_reset();
        cfg_write(0, 1000, 255, 0);
        cfg_write(1, 500, 255, 1);
        tick(10);
        cfg_write(0, 3000, 255, 2);
        cfg_write(1, 2000, 255, 2);
        n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL midrst_pending got=%b exp=0", cfg_ready); end
        #2;
        reset = 1'b1;
        #1;
        n_vec++; if (samples !== 32'h0) begin n_err++; $display("FAIL midrst_samples got=%h exp=0", samples); end
        n_vec++; if (mix !== 8'h0) begin n_err++; $display("FAIL midrst_mix got=%0d exp=0", mix); end
        n_vec++; if (index_zero !== 4'hF) begin n_err++; $display("FAIL midrst_iz got=%b exp=1111", index_zero); end
        for (int c = 0; c < 2; c++) begin
            cfg_ch = 2'(c);
            #1;
            n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready ch=%0d got=%b exp=1", c, cfg_ready); end
        end
        reset = 1'b0;
        for (int t = 0; t < 40; t++) begin
            tick(1);
            n_vec++;
            if (samples !== 32'h0 || index_zero !== 4'hF || mix !== 8'h0) begin
                n_err++; $display("FAIL midrst_idle t=%0d got=%h/%b/%0d exp=0/1111/0", t, samples, index_zero, mix);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        cfg_freq  = 15'd0;
        cfg_amp   = 8'd0;
        cfg_mode  = 2'd0;
        test_reset();
        test_sine();
        test_square();
        test_amplitude();
        test_tri_saw();
        test_deferred();
        test_clamp();
        test_mix();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_signal_generator.md
# multi_signal_generator

Parametrised successor to the single-channel sine generator. Produces NUM_CHANNELS independent periodic waveforms (sine, square, triangle, sawtooth) at the sample clock. Each channel has its own phase accumulator, frequency, amplitude and mode. Configuration updates are deferred to the channel's next phase wrap, so changes never cause clicks. It sits between the note/sequencer logic and the audio PWM/DAC stage, and also supplies an averaged mix of all channels.

## Interface
- NUM_CHANNELS, 4, number of generator channels (1..8)
- FREQ_WIDTH, 14, frequency word width in Hz
- SAMPLE_WIDTH, 8, sample/amplitude width W
- SAMPLE_RATE, 32000, clock rate in Hz; phase modulus
- TABLE_DEPTH, 128, samples per period D (power of 2, divides SAMPLE_RATE)

Ports:
- CLK_32KHz  in  1  sample clock, rising edge
- reset  in  1  asynchronous, active-high; one clock, async active-high reset
- cfg_valid  in  1  configuration write request
- cfg_ready  out  1  high when the addressed channel has no pending update
- cfg_ch  in  clog2(NUM_CHANNELS)  channel being written
- cfg_freq  in  FREQ_WIDTH  frequency in Hz
- cfg_amp  in  W  amplitude, where max = full scale
- cfg_mode  in  2  0 sine, 1 square, 2 triangle, 3 sawtooth
- samples  out  NUM_CHANNELS*W  per-channel samples, channel 0 in LSBs
- mix  out  W  floor(sum of samples / NUM_CHANNELS)
- index_zero  out  NUM_CHANNELS  per channel, high when that channel's table index is 0

## Operation
- Per-channel state: phase register, range [0, SAMPLE_RATE), width clog2(SAMPLE_RATE)+1; active freq, amp and mode; shadow freq, amp and mode; pending flag.
- Accumulator, every cycle:
  - s = phase + freq
  - phase <= (s >= SAMPLE_RATE) ? s − SAMPLE_RATE : s
  - Arithmetic is wide enough that the sum never overflows.
  - "Wrap cycle" means the cycle in which the subtraction occurs.
- Frequency clamp: an accepted freq above SAMPLE_RATE/2 is stored as SAMPLE_RATE/2. A freq of 0 holds the phase.
- Table index: i = floor(phase * D / SAMPLE_RATE). With the defaults this is phase/250.
- Waveforms, with M = 2^W − 1:
  - Sine: round((1 − cos(2πi/D))/2 · M). The table is built at elaboration by a constant function. i=0 gives 0, i=D/2 gives M.
  - Square: M if i < D/2, else 0.
  - Triangle: i < D/2 gives floor(i·M/(D/2)); otherwise floor((D−i)·M/(D/2)).
  - Saw: floor(i·M/(D−1)).
- Amplitude: out = floor((wave·amp + M/2... specifically +127 for W=8, i.e. +floor(M/2)) / M).
- Config handshake:
  - A write is accepted when cfg_valid && cfg_ready.
  - On acceptance, the shadow registers for cfg_ch are loaded and pending is set.
  - cfg_ready = !pending[cfg_ch], evaluated combinationally on cfg_ch.
- Applying a pending update:
  - The shadow is copied to the active registers on the channel's wrap cycle. The phase continues from its wrapped value, with no reset.
  - If active freq is 0, the shadow is copied on the next cycle instead.
  - pending clears when the copy happens.
- Simultaneous events:
  - Acceptance and wrap in the same cycle: the newly accepted values are copied on the next wrap, not this one.
  - A copy and a new acceptance cannot collide, because ready is low while pending.
- Mix: the sum of all channel outputs, W+clog2(NUM_CHANNELS) bits, divided by NUM_CHANNELS (floor).

## Timing
- On reset assertion (asynchronous):
  - Phase = 0.
  - Active and shadow freq = 0, amp = 0, mode = sine.
  - pending = 0.
  - samples = 0, mix = 0, index_zero = all ones.
  - cfg_ready = 1.
- Release: the first accumulation happens on the first rising edge after reset deasserts.
- Outputs are registered with 1-cycle latency: samples, mix and index_zero at edge n+1 reflect the phase, mode and amp that were in the registers after edge n.
- Write to pending: a write accepted at edge k has pending=1 after edge k, so cfg_ready for that channel is low from then on.
- Reset mid-operation: all state returns to reset values immediately and pending writes are discarded.
- A period spans SAMPLE_RATE/freq cycles. index_zero pulses once per period when freq < SAMPLE_RATE/D.

## Test plan
- Sine: reset, then write ch0 freq=1000, amp=255, mode=0.
  - Active applies the cycle after acceptance (freq was 0).
  - Phase steps 0, 1000, 2000, …; index steps 0, 4, 8, ….
  - Wraps every 32 cycles; index_zero[0] pulses every 32 cycles.
  - samples[0] peaks at 255 at index 64.
- Square: ch1 freq=500, amp=255, mode=1.
  - samples[1] is 32 cycles of 255, then 32 cycles of 0, repeating.
  - Amp=128 on the sine peak gives (255·128+127)/255 = 128.
- Deferred update: ch0 running at 1000; write freq=2000 when phase=5000.
  - cfg_ready for ch0 goes low.
  - The channel keeps stepping 1000 until the wrap to 0.
  - Afterwards it steps 2000 and cfg_ready returns high.
  - A second write attempted while pending is not accepted.
- Clamp: write freq=20000, mode=1, amp=255.
  - Effective freq is 16000.
  - The sample alternates 255, 0 every cycle.
- Mix: 4 channels, all square, amp=255, same freq, written while stopped.
  - mix = 255 during high halves.
  - With ch2 and ch3 amp=0: mix = 510/4 = 127.
- Reset mid-run, with pending writes outstanding:
  - All outputs go to 0, index_zero to all ones, cfg_ready to 1.
  - After release, there is no output activity until a new write.
